// File: rtl/pipelined_subtractor32.sv
// Three-stage pipelined subtractor (d = x1 - x2) built on a Kogge-Stone prefix
// carry network, with borrow/overflow/equal/signed-less-than flags and a handoff counter.
module pipelined_subtractor32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             borrow,
  output logic             ovf,
  output logic             eq,
  output logic             lts,
  output logic [CNT_W-1:0] op_count
);

  localparam int LOG = $clog2(WIDTH);
  localparam int L1  = (LOG + 1) / 2;  // prefix levels done in stage 2

  // Group-generate after Kogge-Stone levels [lo, hi).
  function automatic logic [WIDTH-1:0] ks_g(input logic [WIDTH-1:0] g, input logic [WIDTH-1:0] p,
                                            input int lo, input int hi);
    logic [WIDTH-1:0] gn;
    logic [WIDTH-1:0] pn;
    for (int l = lo; l < hi; l++) begin
      gn = g;
      pn = p;
      for (int i = (1 << l); i < WIDTH; i++) begin
        gn[i] = g[i] | (p[i] & g[i-(1<<l)]);
        pn[i] = p[i] & p[i-(1<<l)];
      end
      g = gn;
      p = pn;
    end
    return g;
  endfunction

  // Group-propagate after Kogge-Stone levels [lo, hi).
  function automatic logic [WIDTH-1:0] ks_p(input logic [WIDTH-1:0] p, input int lo, input int hi);
    logic [WIDTH-1:0] pn;
    for (int l = lo; l < hi; l++) begin
      pn = p;
      for (int i = (1 << l); i < WIDTH; i++) begin
        pn[i] = p[i] & p[i-(1<<l)];
      end
      p = pn;
    end
    return p;
  endfunction

  // Handshake: a transfer happens on a clock edge where valid & ready are both 1.
  // Stage k takes new data whenever it is empty or its content moves on, so
  // bubbles collapse while the output is stalled; in_ready is combinational
  // back from out_ready through the three stages.
  logic v1, v2, v3;
  logic ready1, ready2, ready3;

  assign ready3   = ~v3 | out_ready;
  assign ready2   = ~v2 | ready3;
  assign ready1   = ~v1 | ready2;
  assign in_ready = ready1;
  assign out_valid = v3;

  // Stage 1 inputs: carry-in of 1 folded into bit 0 of the generate vector.
  logic [WIDTH-1:0] p_raw, p_fold, g_fold;
  always_comb begin
    p_raw     = x1 ^ ~x2;
    g_fold    = x1 & ~x2;
    g_fold[0] = g_fold[0] | p_raw[0];
    p_fold    = p_raw;
    p_fold[0] = 1'b0;
  end

  logic [WIDTH-1:0] p1, g1, pr1;
  logic             a1, b1;
  logic [WIDTH-1:0] p2, g2, pr2;
  logic             a2, b2;

  // Stage 3 combinational: last prefix levels and flag generation.
  logic [WIDTH-1:0] g_final, carry, d_nx;
  logic             borrow_nx, ovf_nx, eq_nx, lts_nx;
  always_comb begin
    g_final   = ks_g(g2, p2, L1, LOG);
    carry     = {g_final[WIDTH-2:0], 1'b1};
    d_nx      = pr2 ^ carry;
    borrow_nx = ~g_final[WIDTH-1];
    ovf_nx    = (a2 ^ b2) & (d_nx[WIDTH-1] ^ a2);
    eq_nx     = (d_nx == '0);
    lts_nx    = d_nx[WIDTH-1] ^ ovf_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
      p1 <= '0; g1 <= '0; pr1 <= '0; a1 <= 1'b0; b1 <= 1'b0;
      p2 <= '0; g2 <= '0; pr2 <= '0; a2 <= 1'b0; b2 <= 1'b0;
      d <= '0; borrow <= 1'b0; ovf <= 1'b0; eq <= 1'b0; lts <= 1'b0;
      op_count <= '0;
    end else begin
      if (ready1) v1 <= in_valid;
      if (in_valid & ready1) begin
        p1  <= p_fold;
        g1  <= g_fold;
        pr1 <= p_raw;
        a1  <= x1[WIDTH-1];
        b1  <= x2[WIDTH-1];
      end
      if (ready2) v2 <= v1;
      if (v1 & ready2) begin
        g2  <= ks_g(g1, p1, 0, L1);
        p2  <= ks_p(p1, 0, L1);
        pr2 <= pr1;
        a2  <= a1;
        b2  <= b1;
      end
      if (ready3) v3 <= v2;
      if (v2 & ready3) begin
        d      <= d_nx;
        borrow <= borrow_nx;
        ovf    <= ovf_nx;
        eq     <= eq_nx;
        lts    <= lts_nx;
      end
      if (v3 & out_ready) op_count <= op_count + 1'b1;
    end
  end

endmodule

// File: doc/pipelined_subtractor32.md
Name: pipelined_subtractor32

Overview:
- 3-stage pipelined 32-bit subtractor computing d = x1 - x2 with a parallel-prefix carry network. The difference is x1 + ~x2 + 1; the carry-in is folded into bit 0 of the prefix tree.
- Complement of the combinational prefix adders in the arithmetic library; it supplies the subtract/compare path for PPA comparison runs.
- Valid/ready handshake on both sides, with per-stage bubble collapsing and full backpressure.

Parameters:
- WIDTH, 32, operand/result width; must be a power of 2, >= 8.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block accepts operands this cycle
- x1  input  WIDTH  minuend
- x2  input  WIDTH  subtrahend
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- d  output  WIDTH  x1 - x2, modulo 2^WIDTH
- borrow  output  1  1 when unsigned x1 < x2 (inverse of carry-out)
- ovf  output  1  signed overflow
- eq  output  1  1 when x1 == x2
- lts  output  1  signed x1 < x2 (d[MSB] ^ ovf)
- op_count  output  CNT_W  count of results handed off (out_valid & out_ready); wraps to 0

Behaviour:
- Reset: on the clk edge with rst=1, clear all stage valid bits, d, borrow, ovf, eq, lts and op_count to 0. in_ready is 1 in the cycle after reset. An in-flight operation is discarded.
- Transfer rules:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
- Stage 1 (registered on input transfer):
  - p = x1 ^ ~x2, g = x1 & ~x2.
  - Fold in the carry-in: g[0] := g[0] | p[0], p[0] := 0.
  - Register p, g, x1[MSB] and x2[MSB].
- Stage 2: prefix levels 1..log2(WIDTH)/2 rounded up, Kogge-Stone span doubling. Register the group (G,P) pairs and the original p.
- Stage 3: remaining prefix levels, then:
  - d[i] = p_orig[i] ^ c[i], where c[0] = 1 and c[i] = G[i-1:0].
  - The bit-0 prefix value is the folded g[0], and must not be applied twice.
  - borrow = ~G[WIDTH-1:0].
  - ovf = (x1[MSB] ^ x2[MSB]) & (d[MSB] ^ x1[MSB]).
  - eq = (d == 0).
  - lts = d[MSB] ^ ovf.
  - All flags are registered with d.
- Latency: exactly 3 cycles from input transfer to out_valid when there is no backpressure. Throughput is 1 result per cycle.
- Handshake:
  - Stage k advances when next_ready_k = ~valid_k | (stage k+1 advances); out_ready is the ready into stage 3.
  - in_ready = ~valid1 | stage1 advances. This is a combinational chain from out_ready and is accepted.
  - Bubbles collapse: an empty stage accepts its upstream stage even when the output is stalled.
- Stall holding: while out_valid & ~out_ready, d and all flags hold stable, and the pipeline fills to at most 3 entries; in_ready then drops to 0.
- Simultaneous events: with the pipeline full, out_ready=1 and in_valid=1 in the same cycle, output transfer and input transfer both occur and occupancy stays 3.
- Ordering: results emerge in strict input order; none are dropped or duplicated.
- op_count: increments by 1 on each output transfer and wraps from 2^CNT_W-1 to 0.
- Data when idle: d and the flags are don't-care while out_valid=0, but must not change while out_valid=1 and out_ready=0.

Test Plan:
- Basic subtract: after reset, x1=0x0000_0005, x2=0x0000_0003, out_ready=1 -> 3 cycles later out_valid=1, d=0x0000_0002, borrow=0, ovf=0, eq=0, lts=0, op_count=1.
- Wrap and borrow: x1=0, x2=1 -> d=0xFFFF_FFFF, borrow=1, lts=1, ovf=0.
- Signed overflow:
  - x1=0x8000_0000, x2=1 -> d=0x7FFF_FFFF, ovf=1, lts=1, borrow=0.
  - x1=0x7FFF_FFFF, x2=0xFFFF_FFFF -> d=0x8000_0000, ovf=1, lts=0, borrow=1.
- Equality: x1=x2=0xDEAD_BEEF -> d=0, eq=1, borrow=0, lts=0.
- Backpressure:
  - Stream 5 back-to-back pairs (i, 2i) with out_ready=0 -> in_ready drops after 3 accepts and d holds stable.
  - Then set out_ready=1 -> all 5 results appear in order, d=-i mod 2^32, and op_count=5.
- Reset mid-operation: assert rst for 1 cycle with 2 operations in flight -> out_valid=0 next cycle, op_count=0, no stale result emerges later. A random 10k-vector run with random valid/ready matches a golden model (x1-x2, flags).
